// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the Tinker register file and its scoreboard.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 64;
  localparam int REGFILE_DEPTH  = 32;
  localparam int REGFILE_ADDR_W = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic signed [63:0]        reg_data_t;

  // Guards against addresses past the last register when DEPTH is not a power of two.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending bit per register, set by reserves at issue and cleared by writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] r_busy;
  logic             w_wr_valid;
  logic             w_rsv_valid;
  logic             w_rsv_zero;
  logic             w_rsv_busy;
  logic             w_rsv_set;
  logic             w_wr_clr;

  assign w_wr_valid  = addr_in_range(32'(wr_addr), DEPTH) &&
                       !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_rsv_valid = addr_in_range(32'(rsv_addr), DEPTH);
  assign w_rsv_zero  = (ZERO_REG != 0) && (rsv_addr == '0);
  assign w_rsv_busy  = w_rsv_valid ? r_busy[rsv_addr] : 1'b0;

  // A writeback to the same register in this cycle frees it, so the reserve may proceed.
  assign rsv_ok = !rst && rsv_en && w_rsv_valid &&
                  (!w_rsv_busy || (wr_en && (wr_addr == rsv_addr)));

  assign w_rsv_set = rsv_ok && !w_rsv_zero;
  assign w_wr_clr  = wr_en && w_wr_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign r_busy[gi] = 1'b0;
      end else begin : g_bit
        // Set takes priority over clear so a same-cycle reserve leaves the register pending.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_busy[gi] <= 1'b0;
          end else if (w_rsv_set && (rsv_addr == ADDR_W'(gi))) begin
            r_busy[gi] <= 1'b1;
          end else if (w_wr_clr && (wr_addr == ADDR_W'(gi))) begin
            r_busy[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one writeback port and an issue-time busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle writeback data (busy 0) to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic signed [DATA_W-1:0] rd_data_a,
  output logic signed [DATA_W-1:0] rd_data_b,
  output logic                     rd_busy_a,
  output logic                     rd_busy_b,
  output logic                     rd_vld,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_hit;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic              r_rd_vld;

  assign w_wr_hit = wr_en && addr_in_range(32'(wr_addr), DEPTH) &&
                    !((ZERO_REG != 0) && (wr_addr == '0));

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy     (w_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      logic              w_addr_ok;
      logic [DATA_W-1:0] w_data;
      logic              w_busy_bit;
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_busy;

      assign w_addr_ok = addr_in_range(32'(w_rd_addr[gi]), DEPTH) &&
                         !((ZERO_REG != 0) && (w_rd_addr[gi] == '0));

      always_comb begin
        w_data     = '0;
        w_busy_bit = 1'b0;
        if (w_addr_ok) begin
          w_data     = r_mem[w_rd_addr[gi]];
          w_busy_bit = w_busy[w_rd_addr[gi]];
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarded data is complete, so it is reported not busy even if re-reserved this cycle.
        if (w_wr_hit && (wr_addr == w_rd_addr[gi])) begin
          w_data     = wr_data;
          w_busy_bit = 1'b0;
        end
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_data <= '0;
          r_rd_busy <= 1'b0;
        end else if (rd_en) begin
          r_rd_data <= w_data;
          r_rd_busy <= w_busy_bit;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= rd_en;
    end
  end

  assign rd_data_a = g_rd_port[0].r_rd_data;
  assign rd_data_b = g_rd_port[1].r_rd_data;
  assign rd_busy_a = g_rd_port[0].r_rd_busy;
  assign rd_busy_b = g_rd_port[1].r_rd_busy;
  assign rd_vld    = r_rd_vld;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb at default parameters; tracks REGFILE_BYPASS_EN.
module tb_regfile_sb;

  logic               clk = 1'b0;
  logic               rst;
  logic               rd_en;
  logic [4:0]         rd_addr_a;
  logic [4:0]         rd_addr_b;
  logic signed [63:0] rd_data_a;
  logic signed [63:0] rd_data_b;
  logic               rd_busy_a;
  logic               rd_busy_b;
  logic               rd_vld;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [63:0]        wr_data;
  logic               rsv_en;
  logic [4:0]         rsv_addr;
  logic               rsv_ok;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] EXP_SAME_DATA = 64'd9;
  localparam logic [63:0] EXP_SAME_BUSY = 64'd0;
`else
  localparam logic [63:0] EXP_SAME_DATA = 64'd7;
  localparam logic [63:0] EXP_SAME_BUSY = 64'd1;
`endif

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_busy_a (rd_busy_a),
    .rd_busy_b (rd_busy_b),
    .rd_vld    (rd_vld),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_ok    (rsv_ok)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    $display("write r%0d <= %h", a, d);
  endtask

  task automatic do_reserve(input logic [4:0] a, input logic exp_ok, input string tag);
    rsv_en = 1'b1; rsv_addr = a;
    #1;
    check_val(tag, 64'(rsv_ok), 64'(exp_ok));
    tick();
    rsv_en = 1'b0;
    $display("reserve r%0d ok=%0b", a, exp_ok);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b);
    rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b;
    tick();
    rd_en = 1'b0;
    $display("read r%0d=%h busy %0b | r%0d=%h busy %0b vld %0b",
             a, rd_data_a, rd_busy_a, b, rd_data_b, rd_busy_b, rd_vld);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    #12;
    check_val("rst_data_a", rd_data_a, 64'd0);
    check_val("rst_vld", 64'(rd_vld), 64'd0);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    #1;
    check_val("rst_rsv_ok", 64'(rsv_ok), 64'd0);
    rsv_en = 1'b0;
    tick();
    rst = 1'b0;

    // Reset then read
    do_read(5'd1, 5'd2);
    check_val("init_data_a", rd_data_a, 64'd0);
    check_val("init_data_b", rd_data_b, 64'd0);
    check_val("init_busy_a", 64'(rd_busy_a), 64'd0);
    check_val("init_busy_b", 64'(rd_busy_b), 64'd0);
    check_val("init_vld", 64'(rd_vld), 64'd1);
    tick();
    check_val("vld_pulse_end", 64'(rd_vld), 64'd0);

    // Write then read on both ports
    do_write(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(5'd1, 5'd1);
    check_val("wr1_data_a", rd_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("wr1_data_b", rd_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("wr1_busy_a", 64'(rd_busy_a), 64'd0);

    // Zero register
    do_write(5'd0, 64'hDB6D_B6DB_6DB6_DB6D);
    do_read(5'd0, 5'd0);
    check_val("zero_data_a", rd_data_a, 64'd0);
    check_val("zero_data_b", rd_data_b, 64'd0);
    do_reserve(5'd0, 1'b1, "zero_rsv_ok");
    do_read(5'd0, 5'd1);
    check_val("zero_busy", 64'(rd_busy_a), 64'd0);
    check_val("hold_r1", rd_data_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // Scoreboard
    do_reserve(5'd5, 1'b1, "rsv5_first");
    do_reserve(5'd5, 1'b0, "rsv5_again");
    do_read(5'd5, 5'd5);
    check_val("r5_busy_a", 64'(rd_busy_a), 64'd1);
    check_val("r5_busy_b", 64'(rd_busy_b), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'd42;
    do_reserve(5'd5, 1'b1, "wr_rsv5_ok");
    wr_en = 1'b0;
    do_read(5'd5, 5'd0);
    check_val("r5_data", rd_data_a, 64'd42);
    check_val("r5_busy_kept", 64'(rd_busy_a), 64'd1);

    // Same-cycle read and write of reg 3 (reg 3 reserved beforehand)
    do_write(5'd3, 64'd7);
    do_reserve(5'd3, 1'b1, "rsv3_ok");
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd9;
    do_read(5'd3, 5'd3);
    wr_en = 1'b0;
    check_val("same_cyc_data", rd_data_a, EXP_SAME_DATA);
    check_val("same_cyc_busy", 64'(rd_busy_a), EXP_SAME_BUSY);
    do_read(5'd3, 5'd3);
    check_val("r3_after_data", rd_data_b, 64'd9);
    check_val("r3_after_busy", 64'(rd_busy_b), 64'd0);

    // Asynchronous reset between edges
    do_write(5'd4, 64'h55);
    do_reserve(5'd4, 1'b1, "rsv4_ok");
    do_read(5'd4, 5'd4);
    check_val("r4_pre_data", rd_data_a, 64'h55);
    check_val("r4_pre_busy", 64'(rd_busy_a), 64'd1);
    #2;
    rst = 1'b1;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    #1;
    check_val("arst_data_a", rd_data_a, 64'd0);
    check_val("arst_busy_a", 64'(rd_busy_a), 64'd0);
    check_val("arst_vld", 64'(rd_vld), 64'd0);
    check_val("arst_rsv_ok", 64'(rsv_ok), 64'd0);
    #1;
    rst = 1'b0;
    rsv_en = 1'b0;
    $display("async reset pulse");
    do_read(5'd4, 5'd1);
    check_val("r4_post_data", rd_data_a, 64'd0);
    check_val("r4_post_busy", 64'(rd_busy_a), 64'd0);
    check_val("r1_post_data", rd_data_b, 64'd0);
    do_reserve(5'd4, 1'b1, "rsv4_post_ok");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with an integrated busy scoreboard, succeeding the fixed 64-bit, control-coded `register_file`. It holds the processor's architectural registers and provides:
- two registered read ports;
- one write port, used for writeback;
- one reserve port, used at issue to mark destinations pending.

It sits between decode/issue and writeback in the Tinker pipeline.

## Interface
Parameters:
- DATA_W, 64, register width in bits (data is signed).
- DEPTH, 32, number of registers.
- ADDR_W, $clog2(DEPTH), register address width.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  1  read request for both ports.
- rd_addr_a / rd_addr_b  in  ADDR_W  read addresses.
- rd_data_a / rd_data_b  out  DATA_W  registered read data, signed.
- rd_busy_a / rd_busy_b  out  1  registered busy flag of the register read.
- rd_vld  out  1  one-cycle pulse marking rd_data_*/rd_busy_* as updated.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- rsv_en  in  1  reserve request.
- rsv_addr  in  ADDR_W  register to mark busy.
- rsv_ok  out  1  combinational grant for the reserve request.

## Operation
State:
- mem[DEPTH] of DATA_W bits.
- busy[DEPTH] bit vector.

Reset:
- mem and busy are cleared to 0.
- rd_data_a, rd_data_b, rd_busy_a, rd_busy_b and rd_vld are 0.
- rsv_ok is 0 while rst is high.
- Assertion at any time, including mid-operation, clears all state immediately (asynchronous). Requests pending in that cycle are dropped.

Write:
- When wr_en is high at the edge, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- With ZERO_REG=1 and wr_addr=0, the write is ignored.

Reserve:
- rsv_ok = rsv_en & (~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)).
- When rsv_ok is high, busy[rsv_addr] <= 1 at the edge.
- If a write and a reserve target the same address in the same cycle, the final busy value is 1 (reserve wins) and the new data is stored.
- With ZERO_REG=1 and rsv_addr=0, rsv_ok equals rsv_en and busy is not set.

Read:
- When rd_en is high, each port samples mem[addr] and busy[addr] at the edge. Outputs update one cycle later and rd_vld pulses high for that cycle.
- When rd_en is low, rd_data_* and rd_busy_* hold their values and rd_vld is 0.
- Both ports may read the same address.
- With ZERO_REG=1, a read of register 0 returns data 0 and busy 0.

Arithmetic:
- No arithmetic is performed; data passes through unchanged at full DATA_W.
- Addresses >= DEPTH (when DEPTH is not a power of two): reads return 0 with busy 0; writes and reserves are ignored and rsv_ok is 0.

## Timing
- Read latency: 1 cycle from the rd_en edge to valid rd_data_*.
- Write-to-read: a write at edge N is visible to a read sampled at edge N+1 without bypass. With bypass, it is also visible to a read sampled at edge N.
- rsv_ok is combinational from rsv_en, rsv_addr, wr_en, wr_addr and busy. The new busy bit becomes visible one edge later.
- Throughput: one read pair, one write and one reserve can all complete every cycle.

## Configuration
REGFILE_BYPASS_EN:
- Defined: a read sampling the address written in the same cycle returns wr_data and a busy flag of 0. If a reserve to that address also occurs in the same cycle, the read still reports busy 0 (it sees the pre-reserve state).
- Undefined: a read in the same cycle returns the old mem value and the pre-write busy flag.

## Structure
- Shared package regfile_pkg holds:
  - default constants REGFILE_DATA_W=64 and REGFILE_DEPTH=32;
  - typedef reg_addr_t (logic [ADDR_W-1:0] at the default depth);
  - typedef reg_data_t (logic signed [63:0]).
- Sub-module regfile_scoreboard owns the busy vector, the rsv_ok logic and the write-clear logic. The top level owns mem, the read registers and the bypass muxing.

## Test plan
- Reset then read: assert rst, release, read addresses 1 and 2 -> rd_data 0, rd_busy 0, rd_vld high for exactly one cycle.
- Write then read: write 64'hFFFF_FFFF_FFFF_FFFF to reg 1, then read reg 1 on both ports at the next edge -> both return all ones, busy 0.
- Zero register (ZERO_REG=1): write 64'hDB6D_B6DB_6DB6_DB6D to reg 0, then read reg 0 -> returns 0; a reserve of reg 0 gives rsv_ok=1 and busy stays 0.
- Scoreboard:
  - reserve reg 5 -> rsv_ok=1;
  - reserve reg 5 again -> rsv_ok=0;
  - read reg 5 -> busy 1;
  - write 42 to reg 5 while reserving reg 5 in the same cycle -> rsv_ok=1, busy remains 1, data reads 42.
- Same-cycle read/write of reg 3 (old value 7, new value 9) -> returns 9 with busy 0 if REGFILE_BYPASS_EN is defined, else 7 with the prior busy flag.
- Asynchronous reset mid-stream: after reg 4 holds 0x55 and is busy, pulse rst between clock edges -> outputs drop to 0 immediately and a subsequent read of reg 4 returns 0 with busy 0.
